// File: rtl/ball_motion_sched.sv
// Per-frame ball animator: steps a 10.6 position by the velocity, bounces it off the edges, and writes four bytes to the peripheral.
// Output is registered (CALC + 4 writes, one per cycle). Host writes are stalled by host_waitrequest while a burst runs or is pending.
module ball_motion_sched #(
  parameter int          HRES   = 640,
  parameter int          VRES   = 480,
  parameter int          RADIUS = 16,
  parameter logic [15:0] X_INIT = 16'h5000,
  parameter logic [15:0] Y_INIT = 16'h3C00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] cfg_vx,
  input  logic [7:0] cfg_vy,
  input  logic       cfg_load,
  input  logic       host_chipselect,
  input  logic       host_write,
  input  logic [2:0] host_address,
  input  logic [7:0] host_writedata,
  output logic       host_waitrequest,
  output logic       chipselect,
  output logic       write,
  output logic [2:0] address,
  output logic [7:0] writedata,
  output logic       busy,
  output logic [7:0] overrun_cnt
);

  localparam logic [15:0] XMIN = 16'(RADIUS * 64);
  localparam logic [15:0] XMAX = 16'((HRES - 1 - RADIUS) * 64);
  localparam logic [15:0] YMIN = 16'(RADIUS * 64);
  localparam logic [15:0] YMAX = 16'((VRES - 1 - RADIUS) * 64);

  typedef enum logic [2:0] {IDLE, CALC, WR_XH, WR_XL, WR_YH, WR_YL} state_t;

  state_t      state, state_nxt;
  logic        enable, tick_pending;
  logic [15:0] x, y, x_calc, y_calc;
  logic [7:0]  vx, vy, vx_calc, vy_calc;
  logic signed [17:0] nx, ny;
  logic        host_acc;
  logic        cs_nxt, wr_nxt;
  logic [2:0]  addr_nxt;
  logic [7:0]  data_nxt;

  // Negating -128 would overflow, so it clamps to +127.
  function automatic logic [7:0] neg8(input logic [7:0] v);
    return (v == 8'h80) ? 8'h7F : 8'(-v);
  endfunction

  assign busy             = (state != IDLE);
  assign host_waitrequest = busy | tick_pending;
  assign host_acc         = host_chipselect & host_write & ~host_waitrequest;

  always_comb begin
    nx      = $signed({2'b00, x}) + $signed({{10{vx[7]}}, vx});
    ny      = $signed({2'b00, y}) + $signed({{10{vy[7]}}, vy});
    x_calc  = nx[15:0];
    vx_calc = vx;
    y_calc  = ny[15:0];
    vy_calc = vy;
    if (nx < $signed({2'b00, XMIN})) begin
      x_calc  = XMIN;
      vx_calc = neg8(vx);
    end else if (nx > $signed({2'b00, XMAX})) begin
      x_calc  = XMAX;
      vx_calc = neg8(vx);
    end
    if (ny < $signed({2'b00, YMIN})) begin
      y_calc  = YMIN;
      vy_calc = neg8(vy);
    end else if (ny > $signed({2'b00, YMAX})) begin
      y_calc  = YMAX;
      vy_calc = neg8(vy);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Peripheral outputs are registered, so each state's data is prepared one cycle ahead.
  always_comb begin
    state_nxt = state;
    cs_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = 3'd0;
    data_nxt  = 8'h00;
    case (state)
      IDLE: begin
        if (tick_pending || (enable && frame_tick)) state_nxt = CALC;
        if (host_acc && host_address != 3'd3) begin
          cs_nxt   = 1'b1;
          wr_nxt   = 1'b1;
          addr_nxt = host_address;
          data_nxt = host_writedata;
        end
      end
      CALC: begin
        state_nxt = WR_XH;
        {cs_nxt, wr_nxt, addr_nxt, data_nxt} = {2'b11, 3'd4, x_calc[15:8]};
      end
      WR_XH: begin
        state_nxt = WR_XL;
        {cs_nxt, wr_nxt, addr_nxt, data_nxt} = {2'b11, 3'd5, x[7:0]};
      end
      WR_XL: begin
        state_nxt = WR_YH;
        {cs_nxt, wr_nxt, addr_nxt, data_nxt} = {2'b11, 3'd6, y[15:8]};
      end
      WR_YH: begin
        state_nxt = WR_YL;
        {cs_nxt, wr_nxt, addr_nxt, data_nxt} = {2'b11, 3'd7, y[7:0]};
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chipselect   <= 1'b0;
      write        <= 1'b0;
      address      <= 3'd0;
      writedata    <= 8'h00;
      enable       <= 1'b0;
      tick_pending <= 1'b0;
      overrun_cnt  <= 8'h00;
      x            <= X_INIT;
      y            <= Y_INIT;
      vx           <= 8'h00;
      vy           <= 8'h00;
    end else begin
      chipselect <= cs_nxt;
      write      <= wr_nxt;
      address    <= addr_nxt;
      writedata  <= data_nxt;

      if (host_acc && host_address == 3'd3) enable <= host_writedata[0];
      if (host_acc && host_address[2]) begin
        case (host_address[1:0])
          2'd0:    x[15:8] <= host_writedata;
          2'd1:    x[7:0]  <= host_writedata;
          2'd2:    y[15:8] <= host_writedata;
          default: y[7:0]  <= host_writedata;
        endcase
      end

      if (state == CALC) begin
        x  <= x_calc;
        y  <= y_calc;
        vx <= vx_calc;
        vy <= vy_calc;
      end
      if (cfg_load) begin
        vx <= cfg_vx;
        vy <= cfg_vy;
      end

      // At most one tick is queued; every tick that cannot start a burst counts as an overrun.
      if (enable && frame_tick && (busy || tick_pending)) begin
        tick_pending <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end else if (state == IDLE && tick_pending) begin
        tick_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_sched.sv
// Directed bench for ball_motion_sched: table of bursts plus hand-written stall, overrun, disable and reset sequences.
module tb_ball_motion_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [7:0] cfg_vx, cfg_vy;
  logic       cfg_load;
  logic       host_chipselect, host_write;
  logic [2:0] host_address;
  logic [7:0] host_writedata;
  logic       host_waitrequest;
  logic       chipselect, write;
  logic [2:0] address;
  logic [7:0] writedata;
  logic       busy;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int errors = 0;
  int stall;

  always #5 clk = ~clk;

  ball_motion_sched dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_load(cfg_load),
    .host_chipselect(host_chipselect), .host_write(host_write),
    .host_address(host_address), .host_writedata(host_writedata),
    .host_waitrequest(host_waitrequest),
    .chipselect(chipselect), .write(write), .address(address), .writedata(writedata),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  typedef struct {
    string       name;
    bit          set_pos;
    logic [15:0] px, py;
    bit          load;
    logic [7:0]  lvx, lvy;
    logic [7:0]  exh, exl, eyh, eyl;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string n, input bit sp, input logic [15:0] px, input logic [15:0] py,
                              input bit ld, input logic [7:0] lvx, input logic [7:0] lvy,
                              input logic [7:0] exh, input logic [7:0] exl,
                              input logic [7:0] eyh, input logic [7:0] eyl);
    vec_t v;
    v.name = n; v.set_pos = sp; v.px = px; v.py = py;
    v.load = ld; v.lvx = lvx; v.lvy = lvy;
    v.exh = exh; v.exl = exl; v.eyh = eyh; v.eyl = eyl;
    return v;
  endfunction

  function automatic logic [31:0] bus();
    return 32'({busy, chipselect, write, address, writedata});
  endfunction

  function automatic logic [31:0] ebus(input logic b, input logic cs, input logic w,
                                       input logic [2:0] a, input logic [7:0] d);
    return 32'({b, cs, w, a, d});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    for (int i = 0; i < 20 && host_waitrequest; i++) @(negedge clk);
    chk("host_wr idle", 32'(host_waitrequest), 0);
    host_chipselect = 1'b1; host_write = 1'b1; host_address = a; host_writedata = d;
    @(negedge clk);
    host_chipselect = 1'b0; host_write = 1'b0;
    if (a == 3'd3) chk("host_wr addr3 not forwarded", 32'({chipselect, write}), 0);
    else           chk("host_wr forward", 32'({chipselect, write, address, writedata}), 32'({2'b11, a, d}));
  endtask

  task automatic load_v(input logic [7:0] vx, input logic [7:0] vy);
    cfg_vx = vx; cfg_vy = vy; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic run_burst(input string name, input logic [7:0] exh, input logic [7:0] exl,
                           input logic [7:0] eyh, input logic [7:0] eyl);
    logic [7:0] ed[4];
    ed[0] = exh; ed[1] = exl; ed[2] = eyh; ed[3] = eyl;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk({name, " calc"}, bus(), ebus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s wr%0d", name, i), bus(), ebus(1'b1, 1'b1, 1'b1, 3'(4 + i), ed[i]));
    end
    @(negedge clk);
    chk({name, " end"}, bus(), ebus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("basic",      0, 16'h0000, 16'h0000, 1, 8'h40, 8'hE0, 8'h50, 8'h40, 8'h3B, 8'hE0);
    vecs[1] = mk("right_hit",  1, 16'h9BA0, 16'h3BE0, 1, 8'h40, 8'h00, 8'h9B, 8'hC0, 8'h3B, 8'hE0);
    vecs[2] = mk("right_back", 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 8'h9B, 8'h80, 8'h3B, 8'hE0);
    vecs[3] = mk("left_bot",   1, 16'h0420, 16'h73B0, 1, 8'hC0, 8'h20, 8'h04, 8'h00, 8'h73, 8'hC0);
    vecs[4] = mk("left_back",  0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 8'h04, 8'h40, 8'h73, 8'hA0);
    vecs[5] = mk("neg128",     1, 16'h0410, 16'h1000, 1, 8'h80, 8'h7F, 8'h04, 8'h00, 8'h10, 8'h7F);
    vecs[6] = mk("sat127",     0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 8'h04, 8'h7F, 8'h10, 8'hFE);
    vecs[7] = mk("top_hit",    1, 16'h5000, 16'h0410, 1, 8'h00, 8'hC0, 8'h50, 8'h00, 8'h04, 8'h00);

    reset = 1'b1; frame_tick = 1'b0; cfg_vx = 8'h00; cfg_vy = 8'h00; cfg_load = 1'b0;
    host_chipselect = 1'b0; host_write = 1'b0; host_address = 3'd0; host_writedata = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset outputs", bus(), ebus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
    chk("reset waitrequest", 32'(host_waitrequest), 0);
    chk("reset overrun", 32'(overrun_cnt), 0);
    reset = 1'b0;
    @(negedge clk);

    host_wr(3'd3, 8'h01);
    foreach (vecs[k]) begin
      if (vecs[k].set_pos) begin
        host_wr(3'd4, vecs[k].px[15:8]);
        host_wr(3'd5, vecs[k].px[7:0]);
        host_wr(3'd6, vecs[k].py[15:8]);
        host_wr(3'd7, vecs[k].py[7:0]);
      end
      if (vecs[k].load) load_v(vecs[k].lvx, vecs[k].lvy);
      run_burst(vecs[k].name, vecs[k].exh, vecs[k].exl, vecs[k].eyh, vecs[k].eyl);
    end

    // Host write held from WR_XL until the burst finishes.
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    host_chipselect = 1'b1; host_write = 1'b1; host_address = 3'd0; host_writedata = 8'h12;
    stall = 0;
    for (int i = 0; i < 10 && host_waitrequest; i++) begin
      stall++;
      @(negedge clk);
    end
    chk("stall cycles", 32'(stall), 3);
    chk("stall ends in idle", 32'(busy), 0);
    @(negedge clk);
    host_chipselect = 1'b0; host_write = 1'b0;
    chk("stalled write forwarded", 32'({chipselect, write, address, writedata}), 32'({2'b11, 3'd0, 8'h12}));
    @(negedge clk);
    chk("stalled write once", 32'(write), 0);

    // Disabled: ticks ignored, host passes straight through.
    host_wr(3'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      host_chipselect = 1'b1; host_write = 1'b1; host_address = 3'd1; host_writedata = 8'(8'hA0 + i);
      chk("disabled no stall", 32'(host_waitrequest), 0);
      @(negedge clk);
      frame_tick = 1'b0; host_chipselect = 1'b0; host_write = 1'b0;
      chk("disabled passthrough", bus(), ebus(1'b0, 1'b1, 1'b1, 3'd1, 8'(8'hA0 + i)));
      @(negedge clk);
      chk("disabled quiet", 32'({busy, write, overrun_cnt}), 0);
    end

    // Two extra ticks during a burst.
    host_wr(3'd3, 8'h01);
    frame_tick = 1'b1; @(negedge clk);
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("overrun idle gap", 32'({busy, host_waitrequest}), 32'(2'b01));
    chk("overrun count 2", 32'(overrun_cnt), 2);
    @(negedge clk);
    chk("follow-up calc", 32'({busy, write}), 32'(2'b10));
    repeat (5) @(negedge clk);
    chk("follow-up done", 32'({busy, host_waitrequest}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no extra burst", 32'(busy), 0);
    end

    frame_tick = 1'b1;
    repeat (400) @(negedge clk);
    frame_tick = 1'b0;
    chk("overrun saturate", 32'(overrun_cnt), 255);
    for (int i = 0; i < 20 && host_waitrequest; i++) @(negedge clk);
    chk("drain after saturate", 32'(host_waitrequest), 0);
    chk("overrun held", 32'(overrun_cnt), 255);

    // Reset during WR_YH.
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset WR_YH", 32'({write, address}), 32'({1'b1, 3'd6}));
    reset = 1'b1;
    #1;
    chk("async reset outputs", 32'({chipselect, write, busy, host_waitrequest}), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("reset clears overrun", 32'(overrun_cnt), 0);
    @(negedge clk);
    host_wr(3'd3, 8'h01);
    load_v(8'h00, 8'h00);
    run_burst("post_reset", 8'h50, 8'h00, 8'h3C, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion_sched.md
Name: ball_motion_sched

Overview:
- Hardware animation controller sitting between the host Avalon slave port and the VGA ball peripheral's 8-bit register write port.
- On each frame tick (start of vertical blank) it advances a 10.6 fixed-point ball position by a signed velocity and reflects the ball off the screen edges.
- It then issues a 4-write burst (X MSB, X LSB, Y MSB, Y LSB) to the peripheral.
- It shares the peripheral port with host writes: the host has priority while idle and is stalled with waitrequest during a burst.

Parameters:
- HRES, 640: visible pixel columns.
- VRES, 480: visible pixel rows.
- RADIUS, 16: ball radius in pixels; sets the bounce limits.
- X_INIT, 16'h5000: reset X position (320.0 px, 10.6 format).
- Y_INIT, 16'h3C00: reset Y position (240.0 px).

Ports:
- clk, input, 1: system clock (50 MHz).
- reset, input, 1: asynchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse at the start of vertical blank.
- cfg_vx, input, 8: signed X velocity, in 1/64 px per frame.
- cfg_vy, input, 8: signed Y velocity, in 1/64 px per frame.
- cfg_load, input, 1: pulse; loads cfg_vx/cfg_vy into the internal velocity registers.
- host_chipselect, input, 1: host slave select.
- host_write, input, 1: host write strobe.
- host_address, input, 3: host byte address (peripheral register map).
- host_writedata, input, 8: host write data.
- host_waitrequest, output, 1: host write is not accepted this cycle.
- chipselect, output, 1: to peripheral.
- write, output, 1: to peripheral.
- address, output, 3: to peripheral.
- writedata, output, 8: to peripheral.
- busy, output, 1: a burst is in progress (state not IDLE).
- overrun_cnt, output, 8: saturating count of frame ticks that arrived while busy.

Behaviour:

Reset values:
- All peripheral outputs 0; busy 0; overrun_cnt 0; host_waitrequest 0.
- State IDLE; enable 0; tick_pending 0.
- Shadow x=X_INIT, y=Y_INIT; vx=vy=0.

States: IDLE -> CALC -> WR_XH -> WR_XL -> WR_YH -> WR_YL -> IDLE.
- One state per cycle; no stalls inside the sequence.

Handshake:
- host_waitrequest = (state != IDLE) | tick_pending. This is combinational from registers only.
- A host write is accepted when host_chipselect & host_write & !host_waitrequest.

Host address handling:
- Address 3: not forwarded; enable <= writedata[0].
- Addresses 0-2 and 4-7: forwarded on the registered outputs one cycle after acceptance (chipselect=write=1 for exactly one cycle).
- Addresses 4-7 also update the matching shadow byte at the same edge.

Frame ticks:
- frame_tick is ignored while enable=0.
- enable=1 and IDLE with no pending tick: next state CALC.
- frame_tick while state != IDLE: tick_pending <= 1 and overrun_cnt increments, saturating at 255.
- Further ticks while a tick is already pending still increment overrun_cnt; only one tick is ever pending.
- IDLE with tick_pending=1: go to CALC and clear tick_pending.

CALC (peripheral outputs idle this cycle):
- X limits: XMIN = RADIUS<<6 (1024); XMAX = (HRES-1-RADIUS)<<6 (39872).
- Y limits: YMIN = RADIUS<<6; YMAX = (VRES-1-RADIUS)<<6 (29632).
- nx = x + sign_extend(vx), computed as 18-bit signed.
- nx < XMIN: x <= XMIN, vx <= -vx.
- nx > XMAX: x <= XMAX, vx <= -vx.
- Otherwise: x <= nx.
- Y is handled identically with vy and the Y limits.
- Negating -128 saturates to +127.

WR_* states:
- Outputs carry the registered values chipselect=1, write=1, with:
  - address 4 / data x[15:8];
  - address 5 / data x[7:0];
  - address 6 / data y[15:8];
  - address 7 / data y[7:0].
- Data reflects the post-CALC shadow values.

Simultaneous events and precedence:
- frame_tick and an accepted host write in the same IDLE cycle: the host write is forwarded in the next cycle, which is the CALC cycle. CALC uses the shadow values including that host write.
- cfg_load takes effect in any state. If it lands in the same cycle as CALC, the cfg values win over the reflection negation.

Reset mid-burst:
- Outputs deassert immediately (asynchronous reset).
- The burst is abandoned; the shadow position returns to X_INIT/Y_INIT.

Test Plan:
1. Basic burst: reset; host writes addr3=0x01; cfg_load with vx=+64, vy=-32; frame_tick.
   - Required: CALC, then writes (4,0x50), (5,0x40), (6,0x3B), (7,0xE0) on 4 consecutive cycles; busy high for 5 cycles.
2. Right-edge bounce: host writes addr4=0x9B, addr5=0xA0; vx=+64; tick.
   - Required: X writes 0x9B, 0xC0.
   - Next tick: X writes 0x9B, 0x80 (vx is now -64).
3. Host stall: host write addr0=0x12 issued during WR_XL.
   - Required: host_waitrequest=1 until IDLE; then write (0,0x12) appears exactly once, 1 cycle after acceptance.
4. Overrun: two extra frame_ticks during a burst.
   - Required: overrun_cnt=2; exactly one follow-up burst starts the cycle after returning to IDLE.
   - Also: 300 ticks while busy saturate overrun_cnt at 255.
5. Disabled: enable=0; 3 frame_ticks.
   - Required: no peripheral writes; busy stays 0; overrun_cnt stays 0; host writes pass through unstalled.
6. Reset mid-burst: assert reset during WR_YH.
   - Required: write=0 in the same cycle.
   - After enable plus one tick with v=0: writes 0x50, 0x00, 0x3C, 0x00.
